// File: rtl/dom_pkg.sv
// Shared definitions for the DOM masking datapath: FSM states and the
// xorshift32 step used by every mask lane.
package dom_pkg;

  typedef enum logic [1:0] {
    ST_UNSEEDED  = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } dom_state_e;

  localparam int unsigned XS_SHIFT_A = 13;
  localparam int unsigned XS_SHIFT_B = 17;
  localparam int unsigned XS_SHIFT_C = 5;

  // An all-zero xorshift state is a fixed point, so a zero seed is replaced.
  localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_SHIFT_A);
    y = y ^ (y >> XS_SHIFT_B);
    y = y ^ (y << XS_SHIFT_C);
    return y;
  endfunction

endpackage

// File: rtl/dom_xorshift32.sv
// One xorshift32 mask lane: seed load, single-step advance, and the low
// MASK_W bits of the current (pre-advance) state as the lane mask.
module dom_xorshift32
  import dom_pkg::*;
#(
  parameter int MASK_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_en,
  input  logic [31:0]       seed,
  input  logic              adv_en,
  output logic [MASK_W-1:0] mask
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_en) begin
      state_d = (seed == 32'd0) ? ZERO_SEED_SUB : seed;
    end else if (adv_en) begin
      state_d = xorshift32_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= 32'd0;
    end else begin
      state_q <= state_d;
    end
  end

  assign mask = state_q[MASK_W-1:0];

endmodule

// File: rtl/dom_masker.sv
// Splits plaintext words into SHARES Boolean shares using per-lane xorshift32
// masks, with a registered valid/ready output stage and reseed accounting.
module dom_masker
  import dom_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SHARES          = 2,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                      ClkxCI,
  input  logic                      RstxBI,
  input  logic [32*(SHARES-1)-1:0]  SeedxDI,
  input  logic                      SeedValidxSI,
  input  logic [WIDTH-1:0]          DxDI,
  input  logic                      DValidxSI,
  output logic                      DReadyxSO,
  output logic [WIDTH*SHARES-1:0]   QxDO,
  output logic                      QValidxSO,
  input  logic                      QReadyxSI,
  output logic                      ReseedReqxSO
);

  localparam int LANES = SHARES - 1;
  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1);

  dom_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH*SHARES-1:0]   q_q, q_d;
  logic                      qvalid_q, qvalid_d;

  logic [LANES*WIDTH-1:0]    lane_mask;
  logic [WIDTH*SHARES-1:0]   shares;
  logic [WIDTH-1:0]          share0;
  logic                      d_ready;
  logic                      xfer;

  // Seed load blocks input acceptance so a transfer never sees half-loaded lanes.
  assign d_ready = (state_q == ST_RUN) && (!qvalid_q || QReadyxSI) && !SeedValidxSI;
  assign xfer    = DValidxSI && d_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      dom_xorshift32 #(
        .MASK_W (WIDTH)
      ) u_lane (
        .clk     (ClkxCI),
        .srst    (RstxBI),
        .load_en (SeedValidxSI),
        .seed    (SeedxDI[32*gi +: 32]),
        .adv_en  (xfer),
        .mask    (lane_mask[WIDTH*gi +: WIDTH])
      );
      assign shares[WIDTH*(gi+1) +: WIDTH] = lane_mask[WIDTH*gi +: WIDTH];
    end
  endgenerate

  always_comb begin
    share0 = DxDI;
    for (int k = 0; k < LANES; k++) begin
      share0 = share0 ^ lane_mask[WIDTH*k +: WIDTH];
    end
  end

  assign shares[WIDTH-1:0] = share0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (SeedValidxSI) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(RESEED_INTERVAL)) begin
        state_d = ST_EXHAUSTED;
      end
    end
  end

  always_comb begin
    q_d      = q_q;
    qvalid_d = qvalid_q;
    if (xfer) begin
      q_d      = shares;
      qvalid_d = 1'b1;
    end else if (qvalid_q && QReadyxSI) begin
      qvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxBI) begin
      state_q  <= ST_UNSEEDED;
      cnt_q    <= '0;
      q_q      <= '0;
      qvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qvalid_q <= qvalid_d;
    end
  end

  assign DReadyxSO    = d_ready;
  assign QxDO         = q_q;
  assign QValidxSO    = qvalid_q;
  assign ReseedReqxSO = (state_q != ST_RUN);

endmodule

// File: tb/tb_dom_masker.sv
// Bench for dom_masker: three configurations sharing one clock, checked
// against a share/PRNG model built from plain arithmetic.
module tb_dom_masker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Config A: WIDTH=32, SHARES=2, RESEED_INTERVAL=1024
  logic        a_rst, a_sv, a_dv, a_dr, a_qv, a_qr, a_rr;
  logic [31:0] a_seed, a_d;
  logic [63:0] a_q;
  // Config B: WIDTH=32, SHARES=2, RESEED_INTERVAL=4
  logic        b_rst, b_sv, b_dv, b_dr, b_qv, b_qr, b_rr;
  logic [31:0] b_seed, b_d;
  logic [63:0] b_q;
  // Config C: WIDTH=8, SHARES=3, RESEED_INTERVAL=16
  logic        c_rst, c_sv, c_dv, c_dr, c_qv, c_qr, c_rr;
  logic [63:0] c_seed;
  logic [7:0]  c_d;
  logic [23:0] c_q;

  dom_masker #(.WIDTH(32), .SHARES(2), .RESEED_INTERVAL(1024)) u_a (
    .ClkxCI(clk), .RstxBI(a_rst), .SeedxDI(a_seed), .SeedValidxSI(a_sv),
    .DxDI(a_d), .DValidxSI(a_dv), .DReadyxSO(a_dr), .QxDO(a_q),
    .QValidxSO(a_qv), .QReadyxSI(a_qr), .ReseedReqxSO(a_rr));

  dom_masker #(.WIDTH(32), .SHARES(2), .RESEED_INTERVAL(4)) u_b (
    .ClkxCI(clk), .RstxBI(b_rst), .SeedxDI(b_seed), .SeedValidxSI(b_sv),
    .DxDI(b_d), .DValidxSI(b_dv), .DReadyxSO(b_dr), .QxDO(b_q),
    .QValidxSO(b_qv), .QReadyxSI(b_qr), .ReseedReqxSO(b_rr));

  dom_masker #(.WIDTH(8), .SHARES(3), .RESEED_INTERVAL(16)) u_c (
    .ClkxCI(clk), .RstxBI(c_rst), .SeedxDI(c_seed), .SeedValidxSI(c_sv),
    .DxDI(c_d), .DValidxSI(c_dv), .DReadyxSO(c_dr), .QxDO(c_q),
    .QValidxSO(c_qv), .QReadyxSI(c_qr), .ReseedReqxSO(c_rr));

  // xorshift32 written as multiply/divide by powers of two, 32-bit truncating.
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x * 32'd8192);
    y = y ^ (y / 32'd131072);
    y = y ^ (y * 32'd32);
    return y;
  endfunction

  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic seed_a(input logic [31:0] s);
    a_seed = s;
    a_sv   = 1'b1;
    #1;
    n_vec++;
    if (a_dr !== 1'b0) begin n_err++; $display("FAIL seed_a_dready got=%0b want=0", a_dr); end
    cyc();
    a_sv = 1'b0;
    #1;
    n_vec++;
    if (a_rr !== 1'b0) begin n_err++; $display("FAIL seed_a_reseedreq got=%0b want=0", a_rr); end
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_sv = 0; b_sv = 0; c_sv = 0;
    a_dv = 0; b_dv = 0; c_dv = 0;
    a_qr = 0; b_qr = 0; c_qr = 0;
    a_seed = 0; b_seed = 0; c_seed = 0;
    a_d = 0; b_d = 0; c_d = 0;
    cyc(); cyc();
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_dv = 1; a_qr = 1; a_d = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++;
      if (a_dr !== 1'b0 || a_qv !== 1'b0 || a_rr !== 1'b1 || a_q !== 64'd0) begin
        n_err++;
        $display("FAIL reset_unseeded got dr=%0b qv=%0b rr=%0b q=%h want dr=0 qv=0 rr=1 q=0",
                 a_dr, a_qv, a_rr, a_q);
      end
    end
    a_dv = 0;
    $display("reset: unseeded idle checked for 4 cycles");
  endtask

  task automatic test_known_vectors();
    seed_a(32'h1);
    a_qr = 1; a_d = 32'hDEADBEEF; a_dv = 1;
    #1;
    n_vec++;
    if (a_dr !== 1'b1) begin n_err++; $display("FAIL known_dready got=%0b want=1", a_dr); end
    cyc();
    a_d = 32'h0;
    n_vec++;
    if (a_qv !== 1'b1 || a_q !== {32'h0000_0001, 32'hDEADBEEE}) begin
      n_err++; $display("FAIL known_word0 got qv=%0b q=%h want qv=1 q=%h", a_qv, a_q, {32'h1, 32'hDEADBEEE});
    end
    $display("xfer d=deadbeef q=%h", a_q);
    cyc();
    a_dv = 0;
    n_vec++;
    if (a_qv !== 1'b1 || a_q !== {32'h0004_2021, 32'h0004_2021}) begin
      n_err++; $display("FAIL known_word1 got qv=%0b q=%h want qv=1 q=%h", a_qv, a_q, {32'h42021, 32'h42021});
    end
    $display("xfer d=00000000 q=%h", a_q);
    cyc();
    n_vec++;
    if (a_qv !== 1'b0) begin n_err++; $display("FAIL known_drain got qv=%0b want=0", a_qv); end
  endtask

  task automatic test_zero_seed();
    logic [31:0] d;
    seed_a(32'h0);
    d = $urandom;
    a_qr = 1; a_d = d; a_dv = 1;
    cyc();
    a_d = $urandom;
    n_vec++;
    if (a_q !== {32'h1, d ^ 32'h1}) begin
      n_err++; $display("FAIL zero_seed_word0 got=%h want=%h", a_q, {32'h1, d ^ 32'h1});
    end
    $display("xfer zero-seed d=%h q=%h", d, a_q);
    d = a_d;
    cyc();
    a_dv = 0;
    n_vec++;
    if (a_q !== {32'h42021, d ^ 32'h42021}) begin
      n_err++; $display("FAIL zero_seed_word1 got=%h want=%h", a_q, {32'h42021, d ^ 32'h42021});
    end
    cyc();
  endtask

  task automatic test_backpressure_stream();
    logic [31:0] lane, s, d;
    logic [63:0] exp0;
    logic [63:0] eq[$];
    logic [31:0] dq[$];
    s = $urandom;
    seed_a(s);
    lane = fix_seed(s);
    a_qr = 0; d = $urandom; a_d = d; a_dv = 1;
    cyc();
    exp0 = {lane, d ^ lane};
    lane = xs(lane);
    eq.push_back(exp0); dq.push_back(d);
    for (int i = 0; i < 5; i++) begin
      a_d = $urandom;
      #1;
      n_vec++;
      if (a_dr !== 1'b0 || a_qv !== 1'b1 || a_q !== exp0) begin
        n_err++; $display("FAIL hold[%0d] got dr=%0b qv=%0b q=%h want dr=0 qv=1 q=%h", i, a_dr, a_qv, a_q, exp0);
      end
      cyc();
    end
    a_qr = 1;
    for (int i = 0; i <= 8; i++) begin
      n_vec++;
      if (a_qv !== 1'b1 || a_q !== eq[0] || (a_q[63:32] ^ a_q[31:0]) !== dq[0]) begin
        n_err++; $display("FAIL stream[%0d] got qv=%0b q=%h want qv=1 q=%h d=%h", i, a_qv, a_q, eq[0], dq[0]);
      end
      $display("xfer stream[%0d] d=%h q=%h", i, dq[0], a_q);
      void'(eq.pop_front()); void'(dq.pop_front());
      if (i < 8) begin
        d = $urandom; a_d = d; a_dv = 1;
        eq.push_back({lane, d ^ lane}); dq.push_back(d);
        lane = xs(lane);
        #1;
        n_vec++;
        if (a_dr !== 1'b1) begin n_err++; $display("FAIL stream_dready[%0d] got=%0b want=1", i, a_dr); end
      end else begin
        a_dv = 0;
      end
      cyc();
    end
    n_vec++;
    if (a_qv !== 1'b0) begin n_err++; $display("FAIL stream_end got qv=%0b want=0", a_qv); end
  endtask

  task automatic test_exhaustion();
    logic [31:0] lane, s, d;
    logic [63:0] exp_w;
    b_rst = 1; cyc(); b_rst = 0;
    s = $urandom;
    b_seed = s; b_sv = 1; cyc(); b_sv = 0;
    lane = fix_seed(s);
    b_qr = 1;
    for (int i = 0; i < 4; i++) begin
      d = $urandom; b_d = d; b_dv = 1;
      #1;
      n_vec++;
      if (b_dr !== 1'b1) begin n_err++; $display("FAIL exh_dready[%0d] got=%0b want=1", i, b_dr); end
      exp_w = {lane, d ^ lane};
      lane = xs(lane);
      cyc();
      n_vec++;
      if (b_qv !== 1'b1 || b_q !== exp_w) begin
        n_err++; $display("FAIL exh_word[%0d] got qv=%0b q=%h want qv=1 q=%h", i, b_qv, b_q, exp_w);
      end
      $display("xfer exh[%0d] d=%h q=%h", i, d, b_q);
    end
    b_qr = 0; b_d = $urandom;
    #1;
    n_vec++;
    if (b_rr !== 1'b1 || b_dr !== 1'b0) begin
      n_err++; $display("FAIL exhausted got rr=%0b dr=%0b want rr=1 dr=0", b_rr, b_dr);
    end
    cyc();
    n_vec++;
    if (b_qv !== 1'b1 || b_q !== exp_w || b_dr !== 1'b0) begin
      n_err++; $display("FAIL exh_hold got qv=%0b q=%h dr=%0b want qv=1 q=%h dr=0", b_qv, b_q, b_dr, exp_w);
    end
    s = $urandom;
    b_seed = s; b_sv = 1;
    cyc();
    b_sv = 0;
    #1;
    n_vec++;
    if (b_rr !== 1'b0 || b_qv !== 1'b1 || b_q !== exp_w || b_dr !== 1'b0) begin
      n_err++; $display("FAIL reseed_pending got rr=%0b qv=%0b q=%h dr=%0b want rr=0 qv=1 q=%h dr=0",
                        b_rr, b_qv, b_q, b_dr, exp_w);
    end
    lane = fix_seed(s);
    d = $urandom; b_d = d; b_qr = 1;
    #1;
    n_vec++;
    if (b_dr !== 1'b1) begin n_err++; $display("FAIL reseed_dready got=%0b want=1", b_dr); end
    cyc();
    b_dv = 0;
    n_vec++;
    if (b_qv !== 1'b1 || b_q !== {lane, d ^ lane}) begin
      n_err++; $display("FAIL reseed_word got qv=%0b q=%h want qv=1 q=%h", b_qv, b_q, {lane, d ^ lane});
    end
    $display("xfer reseeded d=%h q=%h", d, b_q);
    cyc();
  endtask

  task automatic test_three_shares();
    logic [31:0] l0, l1;
    logic [7:0]  d;
    logic [23:0] exp_w;
    c_rst = 1; cyc(); c_rst = 0;
    c_seed = {32'h2, 32'h1}; c_sv = 1; cyc(); c_sv = 0;
    c_d = 8'hA5; c_dv = 1; c_qr = 1;
    cyc();
    c_dv = 0;
    n_vec++;
    if (c_qv !== 1'b1 || c_q !== 24'h0201A6) begin
      n_err++; $display("FAIL three_known got qv=%0b q=%h want qv=1 q=0201a6", c_qv, c_q);
    end
    $display("xfer 3sh d=a5 q=%h", c_q);
    c_seed = {$urandom, $urandom}; c_sv = 1; cyc(); c_sv = 0;
    l0 = fix_seed(c_seed[31:0]); l1 = fix_seed(c_seed[63:32]);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(255)); c_d = d; c_dv = 1;
      cyc();
      exp_w = {l1[7:0], l0[7:0], d ^ l0[7:0] ^ l1[7:0]};
      l0 = xs(l0); l1 = xs(l1);
      n_vec++;
      if (c_qv !== 1'b1 || c_q !== exp_w) begin
        n_err++; $display("FAIL three_stream[%0d] got qv=%0b q=%h want qv=1 q=%h", i, c_qv, c_q, exp_w);
      end
      $display("xfer 3sh[%0d] d=%h q=%h", i, d, c_q);
    end
  endtask

  task automatic test_mid_reset();
    c_rst = 1; c_dv = 1; c_d = 8'h3C;
    cyc();
    c_rst = 0;
    #1;
    n_vec++;
    if (c_qv !== 1'b0 || c_rr !== 1'b1 || c_dr !== 1'b0 || c_q !== 24'd0) begin
      n_err++; $display("FAIL mid_reset got qv=%0b rr=%0b dr=%0b q=%h want qv=0 rr=1 dr=0 q=0",
                        c_qv, c_rr, c_dr, c_q);
    end
    c_dv = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_zero_seed();
    test_backpressure_stream();
    test_exhaustion();
    test_three_shares();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
